// File: rtl/ex_pkg.sv
// Shared types for the execute stage: ALU opcodes, multiplier FSM states, widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ex_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOR   = 4'd5,
    ALU_SLT   = 4'd6,
    ALU_SLTU  = 4'd7,
    ALU_SLL   = 4'd8,
    ALU_SRL   = 4'd9,
    ALU_SRA   = 4'd10,
    ALU_LUI   = 4'd11,
    ALU_MULT  = 4'd12,
    ALU_MULTU = 4'd13,
    ALU_MFHI  = 4'd14,
    ALU_MFLO  = 4'd15
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  function automatic logic is_mult_op(input alu_op_t op);
    return (op == ALU_MULT) || (op == ALU_MULTU);
  endfunction

endpackage

// File: rtl/ex_mult_seq.sv
// Iterative unsigned shift-add multiplier, one product bit per cycle.
// Latency: MULT_CYCLES steps after the start edge; done is high during the final step.
// Backpressure: none; abort cancels a run in flight, start is ignored while aborting.
// Ports: CLOCK/RESET_N, start (load operands), abort (drop run), mcand/mplier
//        operands, done (this cycle's step is the last), product (64-bit result).
module mult_seq
  import ex_pkg::*;
#(
  parameter int MULT_CYCLES = 32
) (
  input  logic                CLOCK,
  input  logic                RESET_N,
  input  logic                start,
  input  logic                abort,
  input  logic [DATA_W-1:0]   mcand,
  input  logic [DATA_W-1:0]   mplier,
  output logic                done,
  output logic [2*DATA_W-1:0] product
);

  localparam int CW = $clog2(MULT_CYCLES + 1);

  logic [CW-1:0]       count;
  logic                running;
  logic [DATA_W-1:0]   mcand_r;
  logic [2*DATA_W-1:0] prod_r;
  logic [DATA_W:0]     sum;

  // Upper half accumulates; the multiplier sits in the lower half and shifts
  // out one bit per step, so the low bit always selects the next add.
  assign sum     = {1'b0, prod_r[2*DATA_W-1:DATA_W]} + (prod_r[0] ? {1'b0, mcand_r} : '0);
  assign done    = running && (count == CW'(MULT_CYCLES - 1));
  assign product = prod_r;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      count   <= '0;
      running <= 1'b0;
      mcand_r <= '0;
      prod_r  <= '0;
    end else if (abort) begin
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      count   <= '0;
      running <= 1'b1;
      mcand_r <= mcand;
      prod_r  <= {{DATA_W{1'b0}}, mplier};
    end else if (running) begin
      prod_r <= {sum, prod_r[DATA_W-1:1]};
      count  <= count + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, BEQ resolution, destination select, EX/MEM register, HI/LO multiply.
// Latency: 1 cycle for ALU ops; MULT/MULTU take MULT_CYCLES+2 edges to update HI/LO.
// Backpressure: Stall_Out (combinational) holds ID/EX and earlier while a multiply runs.
// Ports: CLOCK/RESET_N, Flush_In squash, *_In ID/EX controls and operands,
//        *_Out registered EX/MEM contents, Stall_Out front-end hold.
module ex_stage
  import ex_pkg::*;
#(
  parameter int MULT_CYCLES = 32
) (
  input  logic                  CLOCK,
  input  logic                  RESET_N,
  input  logic                  Flush_In,
  input  logic                  RegWriteEN_In,
  input  logic                  Mem2RegSEL_In,
  input  logic                  MemWriteEN_In,
  input  logic                  Branch_In,
  input  logic                  ALUSrc_In,
  input  logic                  RegDstSEL_In,
  input  logic [3:0]            ALUCtrl_In,
  input  logic [DATA_W-1:0]     RegData1_In,
  input  logic [DATA_W-1:0]     RegData2_In,
  input  logic [DATA_W-1:0]     PCAddr_In,
  input  logic [15:0]           Imm_In,
  input  logic [REG_ADDR_W-1:0] RTAddr_In,
  input  logic [REG_ADDR_W-1:0] RDAddr_In,
  input  logic [REG_ADDR_W-1:0] Shamt_In,
  output logic                  RegWriteEN_Out,
  output logic                  Mem2RegSEL_Out,
  output logic                  MemWriteEN_Out,
  output logic [DATA_W-1:0]     ALUResult_Out,
  output logic [DATA_W-1:0]     StoreData_Out,
  output logic [REG_ADDR_W-1:0] WriteAddr_Out,
  output logic                  BranchTaken_Out,
  output logic [DATA_W-1:0]     BranchTarget_Out,
  output logic                  Stall_Out
);

  alu_op_t             op;
  mult_state_t         state;
  logic [DATA_W-1:0]   hi_r, lo_r;
  logic                neg_r;
  logic [DATA_W-1:0]   imm_ext, op_b, sub_res, alu_res, br_target;
  logic                op_mult, mult_start, mult_done;
  logic [DATA_W-1:0]   mcand, mplier;
  logic [2*DATA_W-1:0] mult_prod, mult_fixed;

  assign op      = alu_op_t'(ALUCtrl_In);
  assign op_mult = is_mult_op(op);

  // Logical ops take the immediate zero-extended (ANDI/ORI/XORI); all else sign-extends.
  assign imm_ext = ((op == ALU_AND) || (op == ALU_OR) || (op == ALU_XOR)) ?
                   {16'h0, Imm_In} : {{16{Imm_In[15]}}, Imm_In};
  assign op_b    = ALUSrc_In ? imm_ext : RegData2_In;
  assign sub_res = RegData1_In - op_b;

  assign br_target = Branch_In ? (PCAddr_In + {{14{Imm_In[15]}}, Imm_In, 2'b00}) : '0;

  always_comb begin
    alu_res = '0;
    case (op)
      ALU_ADD:   alu_res = RegData1_In + op_b;
      ALU_SUB:   alu_res = sub_res;
      ALU_AND:   alu_res = RegData1_In & op_b;
      ALU_OR:    alu_res = RegData1_In | op_b;
      ALU_XOR:   alu_res = RegData1_In ^ op_b;
      ALU_NOR:   alu_res = ~(RegData1_In | op_b);
      ALU_SLT:   alu_res = {31'h0, $signed(RegData1_In) < $signed(op_b)};
      ALU_SLTU:  alu_res = {31'h0, RegData1_In < op_b};
      ALU_SLL:   alu_res = RegData2_In << Shamt_In;
      ALU_SRL:   alu_res = RegData2_In >> Shamt_In;
      ALU_SRA:   alu_res = $unsigned($signed(RegData2_In) >>> Shamt_In);
      ALU_LUI:   alu_res = {Imm_In, 16'h0};
      ALU_MFHI:  alu_res = hi_r;
      ALU_MFLO:  alu_res = lo_r;
      default:   alu_res = '0;
    endcase
  end

  // Multiplier runs on magnitudes; the sign is reapplied in DONE.
  assign mult_start = (state == IDLE) && op_mult && !Flush_In;
  assign Stall_Out  = (state == BUSY) || mult_start;

  always_comb begin
    mcand  = RegData1_In;
    mplier = RegData2_In;
    if (op == ALU_MULT) begin
      if (RegData1_In[DATA_W-1]) mcand  = -RegData1_In;
      if (RegData2_In[DATA_W-1]) mplier = -RegData2_In;
    end
  end

  assign mult_fixed = neg_r ? -mult_prod : mult_prod;

  mult_seq #(.MULT_CYCLES(MULT_CYCLES)) u_mult (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .start   (mult_start),
    .abort   (Flush_In),
    .mcand   (mcand),
    .mplier  (mplier),
    .done    (mult_done),
    .product (mult_prod)
  );

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      hi_r  <= '0;
      lo_r  <= '0;
      neg_r <= 1'b0;
    end else if (Flush_In) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (op_mult) begin
          state <= BUSY;
          neg_r <= (op == ALU_MULT) && (RegData1_In[DATA_W-1] ^ RegData2_In[DATA_W-1]);
        end
        BUSY: if (mult_done) state <= DONE;
        DONE: begin
          {hi_r, lo_r} <= mult_fixed;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Any multiply-related cycle writes no GPR, so EX/MEM holds a bubble throughout.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      RegWriteEN_Out   <= 1'b0;
      Mem2RegSEL_Out   <= 1'b0;
      MemWriteEN_Out   <= 1'b0;
      ALUResult_Out    <= '0;
      StoreData_Out    <= '0;
      WriteAddr_Out    <= '0;
      BranchTaken_Out  <= 1'b0;
      BranchTarget_Out <= '0;
    end else if (Flush_In || (state != IDLE) || op_mult) begin
      RegWriteEN_Out   <= 1'b0;
      Mem2RegSEL_Out   <= 1'b0;
      MemWriteEN_Out   <= 1'b0;
      ALUResult_Out    <= '0;
      StoreData_Out    <= '0;
      WriteAddr_Out    <= '0;
      BranchTaken_Out  <= 1'b0;
      BranchTarget_Out <= '0;
    end else begin
      RegWriteEN_Out   <= RegWriteEN_In;
      Mem2RegSEL_Out   <= Mem2RegSEL_In;
      MemWriteEN_Out   <= MemWriteEN_In;
      ALUResult_Out    <= alu_res;
      StoreData_Out    <= RegData2_In;
      WriteAddr_Out    <= RegDstSEL_In ? RDAddr_In : RTAddr_In;
      BranchTaken_Out  <= Branch_In && (sub_res == '0);
      BranchTarget_Out <= br_target;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: ALU ops, branch, multiply, flush, reset.
// Latency: inputs change 1 time unit after a rising edge; outputs sampled 1 unit after the next.
// Backpressure: the bench holds multiply inputs stable while Stall_Out is high.
module tb_ex_stage;

  logic        CLOCK, RESET_N, Flush_In;
  logic        RegWriteEN_In, Mem2RegSEL_In, MemWriteEN_In, Branch_In, ALUSrc_In, RegDstSEL_In;
  logic [3:0]  ALUCtrl_In;
  logic [31:0] RegData1_In, RegData2_In, PCAddr_In;
  logic [15:0] Imm_In;
  logic [4:0]  RTAddr_In, RDAddr_In, Shamt_In;
  logic        RegWriteEN_Out, Mem2RegSEL_Out, MemWriteEN_Out, BranchTaken_Out, Stall_Out;
  logic [31:0] ALUResult_Out, StoreData_Out, BranchTarget_Out;
  logic [4:0]  WriteAddr_Out;

  int checks = 0;
  int errors = 0;

  ex_stage #(.MULT_CYCLES(32)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .Flush_In(Flush_In),
    .RegWriteEN_In(RegWriteEN_In), .Mem2RegSEL_In(Mem2RegSEL_In), .MemWriteEN_In(MemWriteEN_In),
    .Branch_In(Branch_In), .ALUSrc_In(ALUSrc_In), .RegDstSEL_In(RegDstSEL_In),
    .ALUCtrl_In(ALUCtrl_In), .RegData1_In(RegData1_In), .RegData2_In(RegData2_In),
    .PCAddr_In(PCAddr_In), .Imm_In(Imm_In), .RTAddr_In(RTAddr_In), .RDAddr_In(RDAddr_In),
    .Shamt_In(Shamt_In),
    .RegWriteEN_Out(RegWriteEN_Out), .Mem2RegSEL_Out(Mem2RegSEL_Out), .MemWriteEN_Out(MemWriteEN_Out),
    .ALUResult_Out(ALUResult_Out), .StoreData_Out(StoreData_Out), .WriteAddr_Out(WriteAddr_Out),
    .BranchTaken_Out(BranchTaken_Out), .BranchTarget_Out(BranchTarget_Out), .Stall_Out(Stall_Out)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  task automatic clear_inputs();
    Flush_In = 0; RegWriteEN_In = 0; Mem2RegSEL_In = 0; MemWriteEN_In = 0;
    Branch_In = 0; ALUSrc_In = 0; RegDstSEL_In = 0; ALUCtrl_In = 4'd0;
    RegData1_In = 0; RegData2_In = 0; PCAddr_In = 0; Imm_In = 0;
    RTAddr_In = 0; RDAddr_In = 0; Shamt_In = 0;
  endtask

  task automatic next_cycle();
    @(posedge CLOCK);
    #1;
  endtask

  // Drive a multiply and count cycles with Stall_Out high; returns in the DONE cycle.
  task automatic run_mult(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
    clear_inputs();
    ALUCtrl_In = op; RegData1_In = a; RegData2_In = b; RegWriteEN_In = 1;
    cyc = 0;
    #1;
    while (Stall_Out && cyc < 100) begin
      cyc++;
      next_cycle();
    end
  endtask

  task automatic read_hilo(input logic [3:0] op);
    clear_inputs();
    ALUCtrl_In = op; RegWriteEN_In = 1; RegDstSEL_In = 1; RDAddr_In = 5'd3;
    next_cycle();
  endtask

  task automatic test_reset();
    RESET_N = 0;
    clear_inputs();
    #12;
    checks++; if (RegWriteEN_Out !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %b want 0", RegWriteEN_Out); end
    checks++; if (ALUResult_Out !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", ALUResult_Out); end
    checks++; if (BranchTaken_Out !== 1'b0 || BranchTarget_Out !== 32'h0) begin errors++; $display("FAIL reset_branch got %b/%h want 0/0", BranchTaken_Out, BranchTarget_Out); end
    checks++; if (WriteAddr_Out !== 5'd0 || StoreData_Out !== 32'h0) begin errors++; $display("FAIL reset_data got %h/%h want 0/0", WriteAddr_Out, StoreData_Out); end
    checks++; if (Stall_Out !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", Stall_Out); end
    @(negedge CLOCK);
    RESET_N = 1;
    next_cycle();
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs, rt;
    logic [15:0] imm;
    logic [4:0]  sh;
    logic        src;
    logic [31:0] exp;
  } vec_t;

  task automatic test_alu();
    vec_t v[14];
    v[0]  = '{4'd0,  32'd5,         32'd7,         16'h0,    5'd0,  1'b0, 32'd12};
    v[1]  = '{4'd1,  32'd5,         32'd7,         16'h0,    5'd0,  1'b0, 32'hFFFFFFFE};
    v[2]  = '{4'd2,  32'hF0F0F0F0,  32'hFF00FF00,  16'h0,    5'd0,  1'b0, 32'hF000F000};
    v[3]  = '{4'd4,  32'hF0F0F0F0,  32'hFF00FF00,  16'h0,    5'd0,  1'b0, 32'h0FF00FF0};
    v[4]  = '{4'd5,  32'h0,         32'h0,         16'h0,    5'd0,  1'b0, 32'hFFFFFFFF};
    v[5]  = '{4'd6,  32'hFFFFFFFF,  32'd1,         16'h0,    5'd0,  1'b0, 32'd1};
    v[6]  = '{4'd7,  32'hFFFFFFFF,  32'd1,         16'h0,    5'd0,  1'b0, 32'd0};
    v[7]  = '{4'd8,  32'h0,         32'd1,         16'h0,    5'd31, 1'b0, 32'h80000000};
    v[8]  = '{4'd9,  32'h0,         32'h80000000,  16'h0,    5'd4,  1'b0, 32'h08000000};
    v[9]  = '{4'd10, 32'h0,         32'h80000000,  16'h0,    5'd4,  1'b0, 32'hF8000000};
    v[10] = '{4'd11, 32'h0,         32'h0,         16'h1234, 5'd0,  1'b0, 32'h12340000};
    v[11] = '{4'd3,  32'h00010000,  32'h0,         16'h8000, 5'd0,  1'b1, 32'h00018000};
    v[12] = '{4'd0,  32'd5,         32'h0,         16'hFFFF, 5'd0,  1'b1, 32'd4};
    v[13] = '{4'd2,  32'hFFFFFFFF,  32'h0,         16'h8001, 5'd0,  1'b1, 32'h00008001};
    // Issued back to back, one op per cycle.
    for (int i = 0; i < 14; i++) begin
      clear_inputs();
      ALUCtrl_In = v[i].op; RegData1_In = v[i].rs; RegData2_In = v[i].rt;
      Imm_In = v[i].imm; Shamt_In = v[i].sh; ALUSrc_In = v[i].src;
      RegWriteEN_In = 1; RegDstSEL_In = 1; RDAddr_In = 5'(i + 1); RTAddr_In = 5'd20;
      next_cycle();
      checks++; if (ALUResult_Out !== v[i].exp) begin errors++; $display("FAIL alu_vec%0d result got %h want %h", i, ALUResult_Out, v[i].exp); end
      checks++; if (WriteAddr_Out !== 5'(i + 1) || RegWriteEN_Out !== 1'b1) begin errors++; $display("FAIL alu_vec%0d dest got %0d/%b want %0d/1", i, WriteAddr_Out, RegWriteEN_Out, i + 1); end
      checks++; if (StoreData_Out !== v[i].rt) begin errors++; $display("FAIL alu_vec%0d store got %h want %h", i, StoreData_Out, v[i].rt); end
    end
    // Store-style: rt destination path, memory controls pass through.
    clear_inputs();
    ALUCtrl_In = 4'd0; RegData1_In = 32'h1000; Imm_In = 16'h0010; ALUSrc_In = 1;
    MemWriteEN_In = 1; Mem2RegSEL_In = 1; RTAddr_In = 5'd9; RDAddr_In = 5'd4; RegData2_In = 32'hCAFEF00D;
    next_cycle();
    checks++; if (WriteAddr_Out !== 5'd9) begin errors++; $display("FAIL rt_dest got %0d want 9", WriteAddr_Out); end
    checks++; if (MemWriteEN_Out !== 1'b1 || Mem2RegSEL_Out !== 1'b1 || RegWriteEN_Out !== 1'b0) begin errors++; $display("FAIL mem_ctrl got %b%b%b want 110", MemWriteEN_Out, Mem2RegSEL_Out, RegWriteEN_Out); end
    checks++; if (ALUResult_Out !== 32'h1010 || StoreData_Out !== 32'hCAFEF00D) begin errors++; $display("FAIL mem_addr got %h/%h want 1010/cafef00d", ALUResult_Out, StoreData_Out); end
  endtask

  task automatic test_branch();
    clear_inputs();
    Branch_In = 1; ALUCtrl_In = 4'd1; RegData1_In = 5; RegData2_In = 5; PCAddr_In = 32'h100; Imm_In = 16'hFFFF;
    next_cycle();
    checks++; if (BranchTaken_Out !== 1'b1) begin errors++; $display("FAIL beq_taken got %b want 1", BranchTaken_Out); end
    checks++; if (BranchTarget_Out !== 32'hFC) begin errors++; $display("FAIL beq_target got %h want fc", BranchTarget_Out); end
    RegData2_In = 6;
    next_cycle();
    checks++; if (BranchTaken_Out !== 1'b0) begin errors++; $display("FAIL beq_not_taken got %b want 0", BranchTaken_Out); end
    checks++; if (BranchTarget_Out !== 32'hFC) begin errors++; $display("FAIL beq_nt_target got %h want fc", BranchTarget_Out); end
  endtask

  task automatic test_signed_mult();
    int cyc;
    run_mult(4'd12, 32'hFFFFFFFD, 32'd7, cyc);
    checks++; if (cyc != 33) begin errors++; $display("FAIL mult_stall_cycles got %0d want 33", cyc); end
    checks++; if (RegWriteEN_Out !== 1'b0 || ALUResult_Out !== 32'h0) begin errors++; $display("FAIL mult_done_bubble got %b/%h want 0/0", RegWriteEN_Out, ALUResult_Out); end
    next_cycle();
    read_hilo(4'd14);
    checks++; if (ALUResult_Out !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", ALUResult_Out); end
    read_hilo(4'd15);
    checks++; if (ALUResult_Out !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo got %h want ffffffeb", ALUResult_Out); end
  endtask

  task automatic test_unsigned_mult();
    int cyc;
    run_mult(4'd13, 32'hFFFFFFFF, 32'd2, cyc);
    checks++; if (cyc != 33) begin errors++; $display("FAIL multu_stall_cycles got %0d want 33", cyc); end
    next_cycle();
    read_hilo(4'd14);
    checks++; if (ALUResult_Out !== 32'h00000001) begin errors++; $display("FAIL multu_hi got %h want 00000001", ALUResult_Out); end
    read_hilo(4'd15);
    checks++; if (ALUResult_Out !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_lo got %h want fffffffe", ALUResult_Out); end
  endtask

  task automatic test_flush();
    clear_inputs();
    Flush_In = 1; ALUCtrl_In = 4'd0; RegWriteEN_In = 1; RegData1_In = 1; RegData2_In = 2;
    RegDstSEL_In = 1; RDAddr_In = 5'd7; Branch_In = 1; PCAddr_In = 32'h40;
    next_cycle();
    checks++; if (RegWriteEN_Out !== 1'b0 || ALUResult_Out !== 32'h0 || WriteAddr_Out !== 5'd0) begin errors++; $display("FAIL flush_add got %b/%h/%0d want 0/0/0", RegWriteEN_Out, ALUResult_Out, WriteAddr_Out); end
    checks++; if (BranchTarget_Out !== 32'h0 || StoreData_Out !== 32'h0) begin errors++; $display("FAIL flush_data got %h/%h want 0/0", BranchTarget_Out, StoreData_Out); end
    // Flush in the middle of a multiply: HI/LO keep the MULTU result.
    clear_inputs();
    ALUCtrl_In = 4'd13; RegData1_In = 3; RegData2_In = 4;
    next_cycle();
    repeat (5) next_cycle();
    checks++; if (Stall_Out !== 1'b1) begin errors++; $display("FAIL busy_stall got %b want 1", Stall_Out); end
    clear_inputs();
    Flush_In = 1;
    next_cycle();
    Flush_In = 0;
    #1;
    checks++; if (Stall_Out !== 1'b0) begin errors++; $display("FAIL flush_busy_stall got %b want 0", Stall_Out); end
    repeat (40) next_cycle();
    read_hilo(4'd14);
    checks++; if (ALUResult_Out !== 32'h00000001) begin errors++; $display("FAIL flush_hi got %h want 00000001", ALUResult_Out); end
    read_hilo(4'd15);
    checks++; if (ALUResult_Out !== 32'hFFFFFFFE) begin errors++; $display("FAIL flush_lo got %h want fffffffe", ALUResult_Out); end
  endtask

  task automatic test_reset_mid_mult();
    clear_inputs();
    ALUCtrl_In = 4'd12; RegData1_In = 5; RegData2_In = 6;
    next_cycle();
    repeat (10) next_cycle();
    RESET_N = 0;
    clear_inputs();
    #1;
    checks++; if (Stall_Out !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got %b want 0", Stall_Out); end
    checks++; if (RegWriteEN_Out !== 1'b0 || ALUResult_Out !== 32'h0 || BranchTaken_Out !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs got %b/%h/%b want 0/0/0", RegWriteEN_Out, ALUResult_Out, BranchTaken_Out); end
    @(negedge CLOCK);
    RESET_N = 1;
    next_cycle();
    read_hilo(4'd14);
    checks++; if (ALUResult_Out !== 32'h0) begin errors++; $display("FAIL rst_mid_hi got %h want 0", ALUResult_Out); end
    read_hilo(4'd15);
    checks++; if (ALUResult_Out !== 32'h0) begin errors++; $display("FAIL rst_mid_lo got %h want 0", ALUResult_Out); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_signed_mult();
    test_unsigned_mult();
    test_flush();
    test_reset_mid_mult();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
